// File: rtl/weight_bram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : weight_bram_ctrl
// Purpose  : Owns one DEPTH x DW weight BRAM and arbitrates it between a host
//            loader (single-word writes) and the neuron MAC datapath, which
//            reads the whole weight vector as a framed burst.
// Ports    : CLK, RST (sync, active-high)
//            START                      - request a read burst (IDLE only)
//            LD_REQ/LD_ADDR/LD_DATA     - host write request, held until LD_ACK
//            LD_ACK/LD_ERR              - write issued / address out of range
//            ADDR/DI/EN/WE, DO          - BRAM port (BRAM samples on negedge)
//            W_OUT/W_VALID/W_LAST       - streamed weights to the accumulator
//            BUSY/DONE                  - burst in progress / burst finished
//            CHKSUM                     - burst checksum
// Options  : define WEIGHT_CHKSUM_EN to build the burst checksum accumulator;
//            otherwise CHKSUM is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module weight_bram_ctrl #(
    parameter int DEPTH = 28,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic          LD_REQ,
    input  logic [AW-1:0] LD_ADDR,
    input  logic [DW-1:0] LD_DATA,
    output logic          LD_ACK,
    output logic          LD_ERR,
    output logic [AW-1:0] ADDR,
    output logic [DW-1:0] DI,
    output logic          EN,
    output logic          WE,
    input  logic [DW-1:0] DO,
    output logic [DW-1:0] W_OUT,
    output logic          W_VALID,
    output logic          W_LAST,
    output logic          BUSY,
    output logic          DONE,
    output logic [DW-1:0] CHKSUM
);

    localparam logic [1:0] c_s_idle  = 2'd0;
    localparam logic [1:0] c_s_load  = 2'd1;
    localparam logic [1:0] c_s_fetch = 2'd2;
    localparam logic [1:0] c_s_flush = 2'd3;

    localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);
    // One extra bit so the range check stays correct even when DEPTH == 2**AW.
    localparam logic [AW:0]   c_depth     = (AW + 1)'(DEPTH);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [AW-1:0] r_cnt;
    logic [DW-1:0] r_w_out;
    logic          r_w_valid;
    logic          r_w_last;
    logic          r_done;

    logic          w_ld_in_range;
    logic          w_rd_issue;
    logic          w_burst_start;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_di;
    logic          w_en;
    logic          w_we;
    logic          w_ld_ack;
    logic          w_ld_err;
    logic          w_busy;

    assign w_ld_in_range = ({1'b0, LD_ADDR} < c_depth);
    assign w_burst_start = (r_state == c_s_idle) && START;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. START wins over LD_REQ in IDLE; the load request
    // simply stays pending and is picked up once the burst returns to IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_s_idle: begin
                if (START) begin
                    w_next_state = c_s_fetch;
                end else if (LD_REQ) begin
                    w_next_state = c_s_load;
                end
            end
            c_s_load: begin
                w_next_state = c_s_idle;
            end
            c_s_fetch: begin
                if (r_cnt == c_last_addr) begin
                    w_next_state = c_s_flush;
                end
            end
            c_s_flush: begin
                w_next_state = c_s_idle;
            end
            default: begin
                w_next_state = c_s_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. The BRAM strobes are decoded straight from the state so
    // a write issued in a LOAD cycle still reaches the BRAM on that cycle's
    // negedge, even if RST is asserted at the same time.
    // ------------------------------------------------------------------
    always_comb begin
        w_addr   = '0;
        w_di     = '0;
        w_en     = 1'b0;
        w_we     = 1'b0;
        w_ld_ack = 1'b0;
        w_ld_err = 1'b0;
        w_busy   = 1'b0;
        case (r_state)
            c_s_load: begin
                w_addr   = LD_ADDR;
                w_di     = LD_DATA;
                w_ld_ack = 1'b1;
                w_en     = w_ld_in_range;
                w_we     = w_ld_in_range;
                w_ld_err = ~w_ld_in_range;
            end
            c_s_fetch: begin
                w_addr = r_cnt;
                w_en   = 1'b1;
                w_busy = 1'b1;
            end
            c_s_flush: begin
                w_busy = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    assign w_rd_issue = w_en & ~w_we;

    // ------------------------------------------------------------------
    // Burst address counter: cleared on burst start, saturates at the last
    // address so it can never point outside the memory.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (w_burst_start) begin
            r_cnt <= '0;
        end else if ((r_state == c_s_fetch) && (r_cnt != c_last_addr)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read-data capture. DO is refreshed by the BRAM on the negedge between
    // the address issue and this posedge, giving a one-cycle read latency.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_w_out   <= '0;
            r_w_valid <= 1'b0;
            r_w_last  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_w_valid <= w_rd_issue;
            r_w_last  <= (r_state == c_s_fetch) && (r_cnt == c_last_addr);
            r_done    <= (r_state == c_s_flush);
            if (w_rd_issue) begin
                r_w_out <= DO;
            end
        end
    end

`ifdef WEIGHT_CHKSUM_EN
    logic [DW-1:0] r_chksum;

    // Accumulates the registered stream, so the last word lands in the DONE
    // cycle and the value then holds until the next burst start clears it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_chksum <= '0;
        end else if (w_burst_start) begin
            r_chksum <= '0;
        end else if (r_w_valid) begin
            r_chksum <= r_chksum + r_w_out;
        end
    end

    assign CHKSUM = r_chksum;
`else
    assign CHKSUM = '0;
`endif

    assign ADDR    = w_addr;
    assign DI      = w_di;
    assign EN      = w_en;
    assign WE      = w_we;
    assign LD_ACK  = w_ld_ack;
    assign LD_ERR  = w_ld_err;
    assign BUSY    = w_busy;
    assign W_OUT   = r_w_out;
    assign W_VALID = r_w_valid;
    assign W_LAST  = r_w_last;
    assign DONE    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_weight_bram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_bram_ctrl
// Purpose  : Self-checking bench for weight_bram_ctrl with a negedge BRAM
//            model, a shadow copy of the expected memory contents, a table of
//            host loads and a scoreboard queue for the streamed weights.
// Options  : WEIGHT_CHKSUM_EN selects the expected CHKSUM behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_bram_ctrl;

    localparam int DEPTH = 28;
    localparam int AW    = 5;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_ack;
    logic          ld_err;
    logic [AW-1:0] addr;
    logic [DW-1:0] di;
    logic          en;
    logic          we;
    logic [DW-1:0] bram_do = '0;
    logic [DW-1:0] w_out;
    logic          w_valid;
    logic          w_last;
    logic          busy;
    logic          done;
    logic [DW-1:0] chksum;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          err;
    } ld_vec_t;
    ld_vec_t ld_tbl[5];

    logic [DW-1:0] mem    [DEPTH];
    logic [DW-1:0] shadow [DEPTH];
    bit            mem_init = 1'b0;

    weight_bram_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK     (clk),
        .RST     (rst),
        .START   (start),
        .LD_REQ  (ld_req),
        .LD_ADDR (ld_addr),
        .LD_DATA (ld_data),
        .LD_ACK  (ld_ack),
        .LD_ERR  (ld_err),
        .ADDR    (addr),
        .DI      (di),
        .EN      (en),
        .WE      (we),
        .DO      (bram_do),
        .W_OUT   (w_out),
        .W_VALID (w_valid),
        .W_LAST  (w_last),
        .BUSY    (busy),
        .DONE    (done),
        .CHKSUM  (chksum)
    );

    always #5 clk = ~clk;

    // Single-port BRAM sampling on the falling edge.
    always @(negedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= DW'(k + 1);
        end else if (en) begin
            if (addr < AW'(DEPTH)) begin
                if (we) mem[addr] <= di;
                else    bram_do   <= mem[addr];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample point of a cycle; also drains the scoreboard on valid words.
    task automatic sample();
        sb_t e;
        @(negedge clk);
        if (w_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_w_valid: got W_VALID=1 W_OUT=%0h required no word", w_out);
            end else begin
                e = sb_q.pop_front();
                check("w_out", w_out, e.data);
                check("w_last", w_last, e.last);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"},    addr,    0);
        check({tag, "_di"},      di,      0);
        check({tag, "_en"},      en,      0);
        check({tag, "_we"},      we,      0);
        check({tag, "_ld_ack"},  ld_ack,  0);
        check({tag, "_ld_err"},  ld_err,  0);
        check({tag, "_w_out"},   w_out,   0);
        check({tag, "_w_valid"}, w_valid, 0);
        check({tag, "_w_last"},  w_last,  0);
        check({tag, "_busy"},    busy,    0);
        check({tag, "_done"},    done,    0);
        check({tag, "_chksum"},  chksum,  0);
    endtask

    // Full burst from IDLE. Starts and ends at posedge+1.
    task automatic run_burst(input bit poke_start);
        logic [DW-1:0] sum;
        sum = '0;
        for (int k = 0; k < DEPTH; k++) begin
            sb_q.push_back('{data: shadow[k], last: (k == DEPTH - 1)});
            sum = sum + shadow[k];
        end
`ifndef WEIGHT_CHKSUM_EN
        sum = '0;
`endif
        start = 1'b1;
        sample();
        check("c0_busy", busy, 0);
        step();
        for (int c = 1; c <= DEPTH + 1; c++) begin
            start = poke_start && (c >= 5) && (c <= 10);
            sample();
            check("burst_busy", busy, 1);
            check("burst_we", we, 0);
            check("burst_ld_ack", ld_ack, 0);
            check("burst_done", done, 0);
            check("burst_w_valid", w_valid, (c >= 2) ? 1 : 0);
            if (c <= DEPTH) begin
                check("burst_en", en, 1);
                check("burst_addr", addr, c - 1);
            end else begin
                check("flush_en", en, 0);
            end
            step();
        end
        start = 1'b0;
        sample();
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_w_valid", w_valid, 0);
        check("done_chksum", chksum, sum);
        check("sb_drained", sb_q.size(), 0);
        step();
    endtask

    // Single host load from IDLE. Starts and ends at posedge+1.
    task automatic do_load(input ld_vec_t v);
        ld_req  = 1'b1;
        ld_addr = v.addr;
        ld_data = v.data;
        sample();
        check("ld_idle_ack", ld_ack, 0);
        step();
        sample();
        check("ld_ack", ld_ack, 1);
        check("ld_err", ld_err, v.err);
        check("ld_en", en, !v.err);
        check("ld_we", we, !v.err);
        check("ld_addr", addr, v.addr);
        check("ld_di", di, v.data);
        if (!v.err) shadow[v.addr] = v.data;
        step();
        ld_req = 1'b0;
        sample();
        check("ld_ack_pulse", ld_ack, 0);
        check("ld_post_en", en, 0);
        step();
    endtask

    initial begin
        ld_tbl[0] = '{addr: 5'd5,  data: 16'hBEEF, err: 1'b0};
        ld_tbl[1] = '{addr: 5'd0,  data: 16'h1234, err: 1'b0};
        ld_tbl[2] = '{addr: 5'd27, data: 16'hA5A5, err: 1'b0};
        ld_tbl[3] = '{addr: 5'd28, data: 16'hDEAD, err: 1'b1};
        ld_tbl[4] = '{addr: 5'd31, data: 16'hFFFF, err: 1'b1};
        for (int k = 0; k < DEPTH; k++) shadow[k] = DW'(k + 1);

        // Reset for two cycles while the BRAM model is preloaded.
        rst = 1'b1; start = 1'b0; ld_req = 1'b0; ld_addr = '0; ld_data = '0;
        mem_init = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_init = 1'b0;
        sample();
        check_zero("reset");
        step();

        // Preloaded burst (1..28), with START pulsed mid-burst to be ignored.
        run_burst(1'b1);

        // Host loads, including out-of-range addresses.
        for (int i = 0; i < 5; i++) do_load(ld_tbl[i]);
        run_burst(1'b0);

        // START and LD_REQ together: burst first, load right after DONE.
        ld_req  = 1'b1;
        ld_addr = 5'd3;
        ld_data = 16'h0C0C;
        run_burst(1'b0);
        sample();
        check("pend_ld_ack", ld_ack, 1);
        check("pend_we", we, 1);
        check("pend_addr", addr, 3);
        check("pend_di", di, 16'h0C0C);
        shadow[3] = 16'h0C0C;
        step();
        ld_req = 1'b0;
        sample();
        check("pend_ack_pulse", ld_ack, 0);
        step();

        // Reset at burst word 10.
        for (int k = 0; k < DEPTH; k++) sb_q.push_back('{data: shadow[k], last: (k == DEPTH - 1)});
        start = 1'b1;
        sample();
        step();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            sample();
            step();
        end
        rst = 1'b1;
        sample();
        check("rstb_addr", addr, 10);
        step();
        rst = 1'b0;
        sample();
        check_zero("rst_burst");
        sb_q.delete();
        step();
        sample();
        check("rstb_no_done", done, 0);
        step();

        // Fresh burst after the abort restarts from address 0.
        run_burst(1'b0);

        // Reset in the LOAD cycle: the write still lands.
        ld_req  = 1'b1;
        ld_addr = 5'd7;
        ld_data = 16'h7777;
        sample();
        step();
        rst = 1'b1;
        sample();
        check("rstl_ld_ack", ld_ack, 1);
        check("rstl_we", we, 1);
        shadow[7] = 16'h7777;
        step();
        rst = 1'b0;
        ld_req = 1'b0;
        sample();
        check_zero("rst_load");
        step();
        run_burst(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/weight_bram_ctrl.md
# weight_bram_ctrl

Controller that owns one 28×16 ANN weight BRAM and shares it between two users: a host loader that writes individual weights, and the neuron MAC datapath, which consumes the full weight vector as a burst. On START it sequences ADDR/EN across the whole memory and streams the words out with valid/last framing. Between bursts it serialises single-word host writes into the BRAM. It sits between the weight BRAM instance and the neuron accumulator.

## Interface
- DEPTH, 28: number of weight words per burst (addresses 0..DEPTH-1).
- AW, 5: address width.
- DW, 16: weight word width.

- CLK  in  1  clock; all controller logic on posedge (the BRAM itself samples on negedge).
- RST  in  1  synchronous, active-high reset.
- START  in  1  request a read burst; sampled in IDLE only.
- LD_REQ  in  1  host write request; hold until LD_ACK.
- LD_ADDR  in  AW  host write address.
- LD_DATA  in  DW  host write data.
- LD_ACK  out  1  one-cycle pulse in the cycle the write is issued to the BRAM.
- LD_ERR  out  1  one-cycle pulse with LD_ACK when LD_ADDR ≥ DEPTH.
- ADDR  out  AW  BRAM address.
- DI  out  DW  BRAM write data.
- EN  out  1  BRAM enable.
- WE  out  1  BRAM write enable.
- DO  in  DW  BRAM read data.
- W_OUT  out  DW  streamed weight.
- W_VALID  out  1  W_OUT holds a valid weight.
- W_LAST  out  1  with W_VALID on the word from address DEPTH-1.
- BUSY  out  1  burst in progress.
- DONE  out  1  one-cycle pulse after the burst completes.
- CHKSUM  out  DW  burst checksum (see Configuration).

## Operation
- FSM states: IDLE, LOAD, FETCH, FLUSH.
- IDLE:
  - If START=1, go to FETCH and clear the address counter. START has priority over a simultaneous LD_REQ; that LD_REQ stays pending.
  - Otherwise, if LD_REQ=1, go to LOAD.
- LOAD (one cycle):
  - ADDR=LD_ADDR, DI=LD_DATA, LD_ACK=1.
  - If LD_ADDR<DEPTH: EN=1, WE=1.
  - If LD_ADDR≥DEPTH: EN=0, WE=0, LD_ERR=1; no write occurs.
  - Return to IDLE.
  - A requester that keeps LD_REQ high after LD_ACK issues a new request.
- FETCH:
  - EN=1, WE=0, ADDR=counter; the counter increments by 1 each cycle.
  - Leaving FETCH after the cycle that issues DEPTH-1 → go to FLUSH.
- FLUSH (one cycle): EN=0; the final word is captured.
- After FLUSH, go to IDLE and pulse DONE.
- W_OUT capture: W_OUT is registered from DO on every posedge that follows a cycle with EN=1 and WE=0. W_VALID is the one-cycle-delayed read-issue flag.
- Ignored inputs:
  - START outside IDLE is ignored.
  - LD_REQ during FETCH or FLUSH waits; there is no LD_ACK until the controller returns to IDLE.
- Counter arithmetic: AW bits, compared against DEPTH-1. It never wraps to an address ≥ DEPTH.

## Timing
- Reset values: state=IDLE, counter=0, and every output 0 (ADDR, DI, EN, WE, LD_ACK, LD_ERR, W_OUT, W_VALID, W_LAST, BUSY, DONE, CHKSUM).
- RST mid-burst or mid-load: the next cycle is IDLE with all outputs 0. A write issued in the same cycle as RST still completes at the BRAM.
- Burst timeline (START high in cycle 0):
  - Cycle 1: ADDR=0, EN=1, BUSY=1.
  - Cycle k+1: ADDR=k.
  - Cycle k+2: W_OUT=W[k], W_VALID=1.
  - Cycle DEPTH+1: FLUSH, W_LAST=1.
  - Cycle DEPTH+2: DONE=1, BUSY=0, state=IDLE.
  - Net result: W_VALID is high for exactly DEPTH consecutive cycles (cycles 2..DEPTH+1).
- START in the DONE cycle is accepted; the next burst's ADDR=0 appears in the following cycle.
- Read latency: 1 cycle from ADDR issue to W_OUT. This relies on the BRAM updating DO on the intervening negedge.
- Host write latency: LD_ACK comes 1 cycle after LD_REQ is sampled in IDLE.

## Configuration
- WEIGHT_CHKSUM_EN defined:
  - CHKSUM is cleared on burst start and accumulates the mod-2^DW sum of every W_OUT with W_VALID=1.
  - CHKSUM is stable from the DONE cycle until the next START.
- WEIGHT_CHKSUM_EN undefined: CHKSUM is tied to 0 and the accumulator logic is absent.

## Test plan
- Reset: assert RST for 2 cycles → every output is 0 and the state is IDLE; START then produces ADDR=0 one cycle later.
- Full burst with BRAM preloaded W[k]=k+1 → W_OUT sequence 1..28 on 28 consecutive W_VALID cycles, W_LAST with 28, DONE one cycle later. With WEIGHT_CHKSUM_EN, CHKSUM=406.
- Load then read: LD_REQ with addr 5, data 16'hBEEF → LD_ACK, WE=1, ADDR=5 one cycle later; the following burst shows W_OUT=16'hBEEF on the 6th valid word.
- Simultaneous START and LD_REQ in IDLE → the burst runs first; LD_ACK appears the cycle after DONE (LOAD entered from IDLE), and no write occurs during FETCH.
- Out-of-range load at addr 28 → LD_ACK and LD_ERR pulse together with EN=0; the BRAM contents are unchanged on read-back.
- RST asserted at burst word 10 → the next cycle has W_VALID=0, BUSY=0, no DONE; a new START restarts from ADDR=0.
